// File: rtl/eq_coef_load_ctl.sv
// eq_coef_load_ctl: sequences equalizer coefficient writes into the per-channel
// EQ coefficient RAM from the eq_ctl software register control word.
// Supports single-channel writes and broadcast writes to every channel. It
// drives a valid/ready write port toward the coefficient RAM arbiter and
// returns a status word for readback.
// Optional feature: define EQ_SYNC_ALIGN_EN to hold each commit until the next
// sync_in pulse, so that coefficient updates start on a spectrum boundary.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no write pending; waiting for a commit edge on ctrl_in[31]
// WAIT_SYNC | commit latched; waiting for sync_in (EQ_SYNC_ALIGN_EN only)
// SINGLE    | one write presented until the arbiter accepts it
// BCAST     | walking every address 0..2^ADDR_W-1 with the latched coefficient

module eq_coef_load_ctl #(
  parameter int ADDR_W = 11,
  parameter int COEF_W = 16
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_in,
  input  logic              sync_in,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [COEF_W-1:0] coef_data,
  output logic              coef_we,
  input  logic              coef_rdy,
  output logic              busy,
  output logic [31:0]       status_out
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
`ifdef EQ_SYNC_ALIGN_EN
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
`endif
  localparam logic [1:0] ST_SINGLE    = 2'd2;
  localparam logic [1:0] ST_BCAST     = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [1:0]  state;
  logic [31:0] ctrl_q;
  logic        ctrl_q_vld;
  logic        bcast_q;
  logic        overrun;
  logic        pending;
  logic [23:0] wr_count;

  logic              commit_evt;
  logic              cmd_bcast;
  logic [ADDR_W-1:0] cmd_addr;
  logic [COEF_W-1:0] cmd_coef;
  logic              accept;

  // ctrl_q_vld stays low for the first sampling edge after reset. A commit bit
  // that is held high through reset therefore reads as a level rather than as a
  // new rising edge.
  assign commit_evt = ctrl_in[31] & ~ctrl_q[31] & ctrl_q_vld;
  assign cmd_bcast  = ctrl_in[30];
  assign cmd_addr   = ctrl_in[COEF_W+ADDR_W-1:COEF_W];
  assign cmd_coef   = ctrl_in[COEF_W-1:0];

  assign coef_we = (state == ST_SINGLE) || (state == ST_BCAST);
  assign accept  = coef_we & coef_rdy;
  assign busy    = (state != ST_IDLE);

`ifdef EQ_SYNC_ALIGN_EN
  assign pending = (state == ST_WAIT_SYNC);
`else
  assign pending = 1'b0;
`endif

  assign status_out = {busy, overrun, pending, 5'b0, wr_count};

  // Signals that this build does not read: reserved control bits, the
  // non-commit bits of ctrl_q, and the sync path when alignment is compiled out.
  wire unused_ok = &{1'b0, ctrl_in, ctrl_q[30:0], sync_in, bcast_q};

  // Register the control word every cycle so that commit edges can be detected.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_q     <= '0;
      ctrl_q_vld <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_in;
      ctrl_q_vld <= 1'b1;
    end
  end

  // Sequencing FSM. It latches the command on a commit edge and then walks the
  // write address.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state     <= ST_IDLE;
      coef_addr <= '0;
      coef_data <= '0;
      bcast_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (commit_evt) begin
            bcast_q   <= cmd_bcast;
            coef_data <= cmd_coef;
            coef_addr <= cmd_bcast ? '0 : cmd_addr;
`ifdef EQ_SYNC_ALIGN_EN
            state     <= ST_WAIT_SYNC;
`else
            state     <= cmd_bcast ? ST_BCAST : ST_SINGLE;
`endif
          end
        end
`ifdef EQ_SYNC_ALIGN_EN
        ST_WAIT_SYNC: begin
          if (sync_in) begin
            state <= bcast_q ? ST_BCAST : ST_SINGLE;
          end
        end
`endif
        ST_SINGLE: begin
          if (coef_rdy) begin
            state <= ST_IDLE;
          end
        end
        ST_BCAST: begin
          if (coef_rdy) begin
            coef_addr <= coef_addr + ADDR_W'(1);
            if (coef_addr == ADDR_LAST) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running count of accepted writes. It wraps modulo 2^24.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      wr_count <= '0;
    end else if (accept) begin
      wr_count <= wr_count + 24'd1;
    end
  end

  // Sticky overrun flag for commits that arrive while busy. If a set and a
  // clear land in the same cycle, the set takes priority.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      overrun <= 1'b0;
    end else if (commit_evt && busy) begin
      overrun <= 1'b1;
    end else if (ctrl_in[29]) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eq_coef_load_ctl.sv
// Self-checking bench for eq_coef_load_ctl. Stimulus pushes the expected writes
// {addr, data} into a scoreboard queue, and a negedge monitor pops and compares
// one entry on every accepted write.
module tb_eq_coef_load_ctl;

  localparam int ADDR_W = 11;
  localparam int COEF_W = 16;
  localparam int N      = 1 << ADDR_W;

  logic              user_clk = 1'b0;
  logic              user_rst_n = 1'b0;
  logic [31:0]       ctrl_in = '0;
  logic              sync_in = 1'b0;
  logic              coef_rdy = 1'b1;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_we;
  logic              busy;
  logic [31:0]       status_out;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int exp_wr   = 0;
  logic [31:0] sb_q[$];

  eq_coef_load_ctl #(.ADDR_W(ADDR_W), .COEF_W(COEF_W)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .ctrl_in    (ctrl_in),
    .sync_in    (sync_in),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_we    (coef_we),
    .coef_rdy   (coef_rdy),
    .busy       (busy),
    .status_out (status_out)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic push_wr(input int a, input int d);
    sb_q.push_back(32'(a) * 32'd65536 + 32'(d));
  endtask

  function automatic logic [31:0] exp_status(input logic b, input logic ov,
                                             input logic pd, input int cnt);
    logic [31:0] c;
    c = 32'(cnt);
    return {b, ov, pd, 5'b0, c[23:0]};
  endfunction

  task automatic wait_idle(input int max, output int cyc);
    cyc = 0;
    tick();
    while (busy && cyc < max) begin
      cyc++;
      tick();
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: every accepted write must match the head of the scoreboard.
  always @(negedge user_clk) begin
    if (user_rst_n && coef_we && coef_rdy) begin
      acc_cnt++;
      if (sb_q.size() == 0)
        chk("unexpected_write", {5'b0, coef_addr, coef_data}, 32'hFFFF_FFFF);
      else
        chk("wr_addr_data", {5'b0, coef_addr, coef_data}, sb_q.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n0, hold, k;

    // Reset state
    #23;
    chk("rst_we", 32'(coef_we), 32'd0);
    chk("rst_addr", 32'(coef_addr), 32'd0);
    chk("rst_data", 32'(coef_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_status", status_out, 32'd0);
    tick();
    user_rst_n = 1'b1;
    tick();

    // Single write: addr 5, coef 0x1234
    ctrl_in = 32'h0005_1234;
    tick();
    ctrl_in = 32'h8005_1234;
    push_wr(5, 16'h1234);
    n0 = acc_cnt;
    wait_idle(10, cyc);
    chk("single_busy_cycles", 32'(cyc), 32'd1);
    chk("single_accepts", 32'(acc_cnt - n0), 32'd1);
    exp_wr++;
    chk("single_status", status_out, exp_status(0, 0, 0, exp_wr));

    // Broadcast of coefficient 0xAB to every channel
    ctrl_in = 32'h0;
    tick();
    ctrl_in = 32'hC000_00AB;
    for (int i = 0; i < N; i++) push_wr(i, 16'h00AB);
    n0 = acc_cnt;
    wait_idle(N + 10, cyc);
    chk("bcast_busy_cycles", 32'(cyc), 32'(N));
    chk("bcast_accepts", 32'(acc_cnt - n0), 32'(N));
    exp_wr += N;
    chk("bcast_status", status_out, exp_status(0, 0, 0, exp_wr));
    chk("bcast_addr_wrap", 32'(coef_addr), 32'd0);

    // Backpressure: addr 7. The control fields change after the commit edge.
    ctrl_in = 32'h0;
    coef_rdy = 1'b0;
    tick();
    ctrl_in = 32'h8007_BEEF;
    push_wr(7, 16'hBEEF);
    n0 = acc_cnt;
    tick();
    ctrl_in = 32'h8123_4567;
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (coef_we && coef_addr == 11'd7 && coef_data == 16'hBEEF) hold++;
      tick();
    end
    coef_rdy = 1'b1;
    if (coef_we && coef_addr == 11'd7 && coef_data == 16'hBEEF) hold++;
    tick();
    chk("bp_hold_cycles", 32'(hold), 32'd11);
    chk("bp_we_after", 32'(coef_we), 32'd0);
    chk("bp_accepts", 32'(acc_cnt - n0), 32'd1);
    exp_wr++;
    chk("bp_status", status_out, exp_status(0, 0, 0, exp_wr));

    // Overrun: a second commit arrives at broadcast address 100 together with
    // err_clr, so the set must win.
    ctrl_in = 32'h0;
    tick();
    ctrl_in = 32'hC000_0055;
    for (int i = 0; i < N; i++) push_wr(i, 16'h0055);
    n0 = acc_cnt;
    tick();
    k = 0;
    while (coef_addr != 11'd99 && k < 200) begin
      k++;
      tick();
    end
    ctrl_in = 32'h0;
    tick();
    chk("ovr_at_addr", 32'(coef_addr), 32'd100);
    ctrl_in = 32'hE000_1111;
    tick();
    chk("ovr_set_wins", 32'(status_out[30]), 32'd1);
    ctrl_in = 32'hC000_1111;
    wait_idle(N + 10, cyc);
    chk("ovr_accepts", 32'(acc_cnt - n0), 32'(N));
    exp_wr += N;
    chk("ovr_status_sticky", status_out, exp_status(0, 1, 0, exp_wr));
    ctrl_in = 32'h2000_0000;
    tick();
    chk("ovr_cleared", status_out, exp_status(0, 0, 0, exp_wr));
    ctrl_in = 32'h0;
    tick();

    // Reset at broadcast address 500, with commit still held high afterwards
    ctrl_in = 32'hC000_00CC;
    for (int i = 0; i < N; i++) push_wr(i, 16'h00CC);
    tick();
    k = 0;
    while (coef_addr != 11'd500 && k < 1000) begin
      k++;
      tick();
    end
    #2;
    user_rst_n = 1'b0;
    #1;
    chk("mrst_we", 32'(coef_we), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_addr", 32'(coef_addr), 32'd0);
    chk("mrst_status", status_out, 32'd0);
    sb_q.delete();
    exp_wr = 0;
    tick();
    tick();
    user_rst_n = 1'b1;
    n0 = acc_cnt;
    repeat (20) tick();
    chk("mrst_no_writes", 32'(acc_cnt - n0), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);
    ctrl_in = 32'h0;
    tick();
    ctrl_in = 32'h8009_0042;
    push_wr(9, 16'h0042);
    wait_idle(10, cyc);
    exp_wr++;
    chk("mrst_new_commit", status_out, exp_status(0, 0, 0, exp_wr));

`ifdef EQ_SYNC_ALIGN_EN
    // A sync_in pulse in the commit cycle is ignored. The write starts after
    // the next sync_in pulse.
    ctrl_in = 32'h0;
    tick();
    ctrl_in = 32'h800A_0077;
    sync_in = 1'b1;
    push_wr(10, 16'h0077);
    tick();
    sync_in = 1'b0;
    hold = 0;
    for (int i = 0; i < 19; i++) begin
      if (status_out[29] && busy && !coef_we) hold++;
      tick();
    end
    if (status_out[29] && busy && !coef_we) hold++;
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    chk("sync_pending_cycles", 32'(hold), 32'd20);
    chk("sync_we_start", 32'(coef_we), 32'd1);
    chk("sync_pending_clr", 32'(status_out[29]), 32'd0);
    tick();
    exp_wr++;
    chk("sync_status", status_out, exp_status(0, 0, 0, exp_wr));
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
